// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the memory arbiter slice.
//   - Memory size option encodings driven on mem_option.
//   - FSM state encoding, also exported on the arbiter's debug state port.
//   - Port indices used in the two-bit request/grant vectors.
package memory_arbiter_pkg;

  localparam logic [1:0] OPT_BYTE = 2'b00;
  localparam logic [1:0] OPT_HALF = 2'b01;
  localparam logic [1:0] OPT_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SERVE_IF = 2'b01,
    SERVE_D  = 2'b10
  } arb_state_e;

  // Bit positions inside req/grant vectors.
  localparam int PORT_IF = 0;
  localparam int PORT_D  = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin grant logic (purely combinational).
// Ports:
//   req[1:0]   in   request vector, bit 0 = instruction port, bit 1 = data port
//   last       in   port served most recently (0 = instruction, 1 = data)
//   grant[1:0] out  one-hot grant, all zero when nothing is requested
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      // On a tie the port that was not served last wins.
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one
// single-cycle memory. Each granted transaction occupies one SERVE cycle;
// the port's ack pulses in the following cycle together with registered
// read data.
// Ports:
//   clk, reset                       clock, async active-high reset
//   if_req/if_address                instruction read request (level, held until ack)
//   if_ack/if_read_data              completion pulse and registered instruction word
//   d_req/d_write/d_option           data request, store flag, access size
//   d_address/d_write_data           data byte address and store data
//   d_ack/d_read_data                completion pulse and registered load data
//   mem_read/mem_write/mem_option    memory strobes and size (from latched values)
//   mem_address/mem_write_data       memory address and store data (latched)
//   mem_read_data                    combinational read data from memory
//   dbg_state                        current FSM state
//
// Handshake: a requester raises req and holds it, with stable request
// fields, until it sees its ack; the transaction is complete in the ack
// cycle. Holding req high during the ack cycle issues the next transaction,
// which is arbitrated in that same cycle.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter bit FIRST_GRANT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_address,
  output logic                  if_ack,
  output logic [31:0]           if_read_data,
  input  logic                  d_req,
  input  logic                  d_write,
  input  logic [1:0]            d_option,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [31:0]           d_write_data,
  output logic                  d_ack,
  output logic [31:0]           d_read_data,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [1:0]            mem_option,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  output arb_state_e            dbg_state
);

  arb_state_e            state_q, state_d;
  logic [1:0]            grant;
  // Port served most recently; resetting it to the opposite of FIRST_GRANT
  // makes the first tie go to FIRST_GRANT.
  logic                  rr_last_q;
  logic [ADDR_WIDTH-1:0] lat_addr_q;
  logic [1:0]            lat_opt_q;
  logic                  lat_write_q;
  logic [31:0]           lat_wdata_q;

  rr_arbiter2 u_rr (
    .req   ({d_req, if_req}),
    .last  (rr_last_q),
    .grant (grant)
  );

  // Next-state and memory strobes. Strobes come straight from the state
  // register so that an asynchronous reset drops them immediately.
  always_comb begin
    state_d   = state_q;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant[PORT_IF])     state_d = SERVE_IF;
        else if (grant[PORT_D]) state_d = SERVE_D;
      end
      SERVE_IF: begin
        mem_read = 1'b1;
        // The served port's own req is ignored here: it is still held high
        // for the transaction in flight.
        state_d  = d_req ? SERVE_D : IDLE;
      end
      SERVE_D: begin
        mem_read  = !lat_write_q;
        mem_write = lat_write_q;
        state_d   = if_req ? SERVE_IF : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request latch and round-robin pointer, loaded on entry to a SERVE state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q   <= !FIRST_GRANT;
      lat_addr_q  <= '0;
      lat_opt_q   <= '0;
      lat_write_q <= 1'b0;
      lat_wdata_q <= '0;
    end else if (state_d == SERVE_IF) begin
      rr_last_q   <= 1'b0;
      lat_addr_q  <= if_address;
      lat_opt_q   <= OPT_WORD;
      lat_write_q <= 1'b0;
    end else if (state_d == SERVE_D) begin
      rr_last_q   <= 1'b1;
      lat_addr_q  <= d_address;
      lat_opt_q   <= d_option;
      lat_write_q <= d_write;
      lat_wdata_q <= d_write_data;
    end
  end

  // Completion: ack and read data registered on the edge ending SERVE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_ack       <= 1'b0;
      d_ack        <= 1'b0;
      if_read_data <= '0;
      d_read_data  <= '0;
    end else begin
      if_ack <= (state_q == SERVE_IF);
      d_ack  <= (state_q == SERVE_D);
      if (state_q == SERVE_IF) if_read_data <= mem_read_data;
      if ((state_q == SERVE_D) && !lat_write_q) d_read_data <= mem_read_data;
    end
  end

  assign mem_option     = lat_opt_q;
  assign mem_address    = lat_addr_q;
  assign mem_write_data = lat_wdata_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int AW = 32;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_address;
  logic          if_ack;
  logic [31:0]   if_read_data;
  logic          d_req;
  logic          d_write;
  logic [1:0]    d_option;
  logic [AW-1:0] d_address;
  logic [31:0]   d_write_data;
  logic          d_ack;
  logic [31:0]   d_read_data;
  logic          mem_read;
  logic          mem_write;
  logic [1:0]    mem_option;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_data;
  logic [31:0]   mem_read_data;
  arb_state_e    dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  memory_arbiter #(.ADDR_WIDTH(AW), .FIRST_GRANT(1'b0)) dut (
    .clk            (clk),
    .reset          (reset),
    .if_req         (if_req),
    .if_address     (if_address),
    .if_ack         (if_ack),
    .if_read_data   (if_read_data),
    .d_req          (d_req),
    .d_write        (d_write),
    .d_option       (d_option),
    .d_address      (d_address),
    .d_write_data   (d_write_data),
    .d_ack          (d_ack),
    .d_read_data    (d_read_data),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_option     (mem_option),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .dbg_state      (dbg_state)
  );

  // ---------------- memory model (little-endian lanes) ----------------
  logic [31:0] mem [0:255];
  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (mem_write) begin
      case (mem_option)
        2'b00:   mem[mem_address[9:2]][{mem_address[1:0], 3'b000} +: 8] <= mem_write_data[7:0];
        2'b01:   mem[mem_address[9:2]][{mem_address[1], 4'b0000} +: 16] <= mem_write_data[15:0];
        default: mem[mem_address[9:2]] <= mem_write_data;
      endcase
    end
  end

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  int         rd_cnt = 0;
  int         rd_last_cyc = -1;
  logic [1:0] last_opt = 2'b00;

  always @(negedge clk) begin
    if (mem_read) begin
      rd_cnt++;
      rd_last_cyc = cyc;
    end
    if (mem_read || mem_write) last_opt = mem_option;
  end

  // ---------------- scoreboard ----------------
  logic [31:0] if_exp_q[$];
  logic [31:0] d_exp_q[$];
  int          if_ack_cyc_q[$];
  int          d_ack_cyc_q[$];
  logic [31:0] d_hold = '0;   // d_read_data expected across stores

  always @(negedge clk) begin
    if (!reset) begin
      if (if_ack) begin
        if_ack_cyc_q.push_back(cyc);
        if (if_exp_q.size() == 0) check("if_ack_unexpected", 32'(if_ack), 32'd0);
        else check("if_read_data", if_read_data, if_exp_q.pop_front());
      end
      if (d_ack) begin
        d_ack_cyc_q.push_back(cyc);
        if (d_exp_q.size() == 0) check("d_ack_unexpected", 32'(d_ack), 32'd0);
        else check("d_read_data", d_read_data, d_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic if_txn(input logic [31:0] addr, input logic [31:0] exp);
    if_exp_q.push_back(exp);
    if_address = addr;
    if_req     = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_ack) break;
    end
    check("if_ack_seen", 32'(if_ack), 32'd1);
    if_req = 1'b0;
  endtask

  task automatic d_txn(input logic wr, input logic [1:0] opt, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp);
    if (wr) d_exp_q.push_back(d_hold);
    else begin
      d_exp_q.push_back(exp);
      d_hold = exp;
    end
    d_write      = wr;
    d_option     = opt;
    d_address    = addr;
    d_write_data = wdata;
    d_req        = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (d_ack) break;
    end
    check("d_ack_seen", 32'(d_ack), 32'd1);
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b1;
    d_hold = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_ack"},   32'(if_ack), 32'd0);
    check({tag, "_d_ack"},    32'(d_ack), 32'd0);
    check({tag, "_if_rdata"}, if_read_data, 32'd0);
    check({tag, "_d_rdata"},  d_read_data, 32'd0);
    check({tag, "_mem_read"}, 32'(mem_read), 32'd0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    check({tag, "_mem_addr"}, mem_address, 32'd0);
    check({tag, "_mem_opt"},  32'(mem_option), 32'd0);
    check({tag, "_mem_wdata"}, mem_write_data, 32'd0);
    check({tag, "_state"},    32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  int t0;

  initial begin
    reset        = 1'b1;
    if_req       = 1'b0;
    if_address   = '0;
    d_req        = 1'b0;
    d_write      = 1'b0;
    d_option     = 2'b00;
    d_address    = '0;
    d_write_data = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[4]  = 32'h0000_0013;   // 0x10
    mem[16] = 32'h1122_3344;   // 0x40
    mem[17] = 32'hCAFE_F00D;   // 0x44
    mem[32] = 32'h5555_5555;   // 0x80
    for (int i = 0; i < 4; i++) begin
      mem[64 + i]  = 32'hA000_0001 + i;  // 0x100..0x10C
      mem[128 + i] = 32'hD000_0001 + i;  // 0x200..0x20C
    end

    // Reset state
    @(negedge clk);
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single instruction fetch: ack two cycles after req, one read cycle
    t0 = cyc;
    rd_cnt = 0;
    if_ack_cyc_q.delete();
    if_txn(32'h10, 32'h0000_0013);
    @(negedge clk);
    check("if_ack_cycle", if_ack_cyc_q[0], t0 + 2);
    check("if_mem_read_count", rd_cnt, 1);
    check("if_mem_read_cycle", rd_last_cyc, t0 + 1);

    // Byte store then word load of the same word
    t0 = cyc;
    d_ack_cyc_q.delete();
    d_txn(1'b1, 2'b00, 32'h20, 32'hAABB_CCDD, 32'h0);
    @(negedge clk);
    check("st_ack_cycle", d_ack_cyc_q[0], t0 + 2);
    check("st_byte_mem", mem[8], 32'h0000_00DD);
    d_txn(1'b0, 2'b10, 32'h20, 32'h0, 32'h0000_00DD);

    // Half store to upper half, word load back, option 11 passed through
    d_txn(1'b1, 2'b01, 32'h42, 32'h1234_5678, 32'h0);
    d_txn(1'b0, 2'b10, 32'h40, 32'h0, 32'h5678_3344);
    d_txn(1'b0, 2'b11, 32'h44, 32'h0, 32'hCAFE_F00D);
    @(negedge clk);
    check("opt11_passthrough", 32'(last_opt), 32'd3);
    check("idle_hold_addr", mem_address, 32'h44);
    check("idle_hold_opt", 32'(mem_option), 32'd3);
    check("idle_mem_read", 32'(mem_read), 32'd0);
    check("if_rdata_hold", if_read_data, 32'h0000_0013);

    // Simultaneous requests right after reset: instruction port first
    do_reset();
    check("post_reset_if_rdata", if_read_data, 32'd0);
    t0 = cyc;
    if_ack_cyc_q.delete();
    d_ack_cyc_q.delete();
    fork
      if_txn(32'h10, 32'h0000_0013);
      d_txn(1'b0, 2'b10, 32'h20, 32'h0, 32'h0000_00DD);
      begin
        @(negedge clk);
        check("tie_state_c1", 32'(dbg_state), 32'(SERVE_IF));
        @(negedge clk);
        check("tie_state_c2", 32'(dbg_state), 32'(SERVE_D));
      end
    join
    @(negedge clk);
    check("tie_if_ack_cycle", if_ack_cyc_q[0], t0 + 2);
    check("tie_d_ack_cycle", d_ack_cyc_q[0], t0 + 3);

    // Both ports continuously busy: strict alternation, one ack per cycle
    t0 = cyc;
    if_ack_cyc_q.delete();
    d_ack_cyc_q.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) if_txn(32'h100 + 4 * i, 32'hA000_0001 + i);
      end
      begin
        for (int i = 0; i < 4; i++) d_txn(1'b0, 2'b10, 32'h200 + 4 * i, 32'h0, 32'hD000_0001 + i);
      end
    join
    @(negedge clk);
    check("alt_if_ack_count", if_ack_cyc_q.size(), 4);
    check("alt_d_ack_count", d_ack_cyc_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < if_ack_cyc_q.size()) check("alt_if_ack_cycle", if_ack_cyc_q[i], t0 + 2 + 2 * i);
      if (i < d_ack_cyc_q.size())  check("alt_d_ack_cycle", d_ack_cyc_q[i], t0 + 3 + 2 * i);
    end

    // Reset in the middle of a store's SERVE cycle aborts it
    d_address    = 32'h80;
    d_write      = 1'b1;
    d_option     = 2'b10;
    d_write_data = 32'hFFFF_FFFF;
    d_req        = 1'b1;
    @(negedge clk);
    check("abort_state_serve", 32'(dbg_state), 32'(SERVE_D));
    check("abort_mem_write_before", 32'(mem_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("abort_mem_write_after", 32'(mem_write), 32'd0);
    d_req = 1'b0;
    d_hold = '0;
    @(negedge clk);
    check_all_zero("abort");
    check("abort_mem_word", mem[32], 32'h5555_5555);
    reset = 1'b0;
    d_ack_cyc_q.delete();
    repeat (3) @(negedge clk);
    check("abort_no_d_ack", d_ack_cyc_q.size(), 0);
    check("abort_mem_word_later", mem[32], 32'h5555_5555);
    check("sb_if_empty", if_exp_q.size(), 0);
    check("sb_d_empty", d_exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
